// File: rtl/eq_run_pkg.sv
// Shared definitions for the equal-run arbiter: FSM state encodings, a clog2
// helper and the default counter widths.
package eq_run_pkg;

  // FSM states (plain constants so older tools can consume them)
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  // Ceiling log2, never less than 1 so it is always usable as a vector width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Width of a counter that must hold the value max_val itself.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return clog2(max_val + 1);
  endfunction

  localparam int unsigned DEF_N_CH        = 4;
  localparam int unsigned DEF_RUN_LEN     = 4;
  localparam int unsigned DEF_MAX_SAMPLES = 16;
  localparam int unsigned DEF_RUN_W       = cnt_width(DEF_RUN_LEN);
  localparam int unsigned DEF_SMP_W       = cnt_width(DEF_MAX_SAMPLES);

endpackage

// File: rtl/eq_run_arbiter_if.sv
// Channel-side bus of the equal-run arbiter.
//   req, a, b : per-channel request and operand pair (driven by requesters)
//   grant     : one-hot grant, 0 when idle
//   busy      : arbiter is serving or reporting
//   done      : one-cycle result strobe; hit / aborted qualify it
//   done_ch   : index of the last served channel, held until the next done
// master = requester side, slave = arbiter side.
interface eq_run_arbiter_if import eq_run_pkg::*; #(
  parameter int unsigned N_CH = DEF_N_CH
) ();
  localparam int unsigned CH_W = clog2(N_CH);

  logic [N_CH-1:0] req;
  logic [N_CH-1:0] a;
  logic [N_CH-1:0] b;
  logic [N_CH-1:0] grant;
  logic            busy;
  logic            done;
  logic            hit;
  logic            aborted;
  logic [CH_W-1:0] done_ch;

  modport master (
    output req, a, b,
    input  grant, busy, done, hit, aborted, done_ch
  );

  modport slave (
    input  req, a, b,
    output grant, busy, done, hit, aborted, done_ch
  );
endinterface

// File: rtl/eq_run_counter.sv
// Shared equal-run detector. Counts accepted samples and the current run of
// consecutive a==b samples.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear of both counters (has priority over en)
//   en       : accept the current (a, b) sample
//   a, b     : operand pair of the granted channel
//   run_hit  : run counter equals RUN_LEN
//   smp_out  : sample counter equals MAX_SAMPLES
module eq_run_counter import eq_run_pkg::*; #(
  parameter int unsigned RUN_LEN     = DEF_RUN_LEN,
  parameter int unsigned MAX_SAMPLES = DEF_MAX_SAMPLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic run_hit,
  output logic smp_out
);
  localparam int unsigned RUN_W = cnt_width(RUN_LEN);
  localparam int unsigned SMP_W = cnt_width(MAX_SAMPLES);

  logic [RUN_W-1:0] run_cnt_q;
  logic [SMP_W-1:0] smp_cnt_q;

  // The controller stops enabling once either limit is reached, so neither
  // counter can wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt_q <= '0;
      smp_cnt_q <= '0;
    end else if (clr) begin
      run_cnt_q <= '0;
      smp_cnt_q <= '0;
    end else if (en) begin
      smp_cnt_q <= smp_cnt_q + SMP_W'(1);
      run_cnt_q <= (a == b) ? run_cnt_q + RUN_W'(1) : '0;
    end
  end

  assign run_hit = (run_cnt_q == RUN_W'(RUN_LEN));
  assign smp_out = (smp_cnt_q == SMP_W'(MAX_SAMPLES));

endmodule

// File: rtl/eq_run_arbiter.sv
// Round-robin arbiter that time-shares one equal-run detector among N_CH
// requesters. A granted channel scores a hit after RUN_LEN consecutive a==b
// samples, a miss after MAX_SAMPLES samples, or an abort if it drops req.
//   clk, rst : clock, async active-high reset
//   bus      : channel bus (slave side): req/a/b in; grant, busy, done, hit,
//              aborted, done_ch out (all registered)
module eq_run_arbiter import eq_run_pkg::*; #(
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned RUN_LEN     = DEF_RUN_LEN,
  parameter int unsigned MAX_SAMPLES = DEF_MAX_SAMPLES
) (
  input  logic              clk,
  input  logic              rst,
  eq_run_arbiter_if.slave   bus
);
  localparam int unsigned CH_W = clog2(N_CH);

  if (RUN_LEN < 1 || RUN_LEN > MAX_SAMPLES) begin : g_param_err
    $error("eq_run_arbiter: need 1 <= RUN_LEN <= MAX_SAMPLES");
  end

  logic [1:0]      state_q, state_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CH_W-1:0] gidx_q, gidx_d;
  logic [N_CH-1:0] grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            hit_q, hit_d;
  logic            aborted_q, aborted_d;
  logic [CH_W-1:0] done_ch_q, done_ch_d;

  logic            pick_valid;
  logic [CH_W-1:0] pick_idx;
  logic            g_req, g_a, g_b;
  logic            run_hit, smp_out;
  logic            cnt_clr, cnt_en;

  // First pending request after the last served channel, wrapping around.
  always_comb begin
    int unsigned cand;
    cand       = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      cand = (32'(ptr_q) + i) % N_CH;
      if (!pick_valid && bus.req[CH_W'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = CH_W'(cand);
      end
    end
  end

  assign g_req = bus.req[gidx_q];
  assign g_a   = bus.a[gidx_q];
  assign g_b   = bus.b[gidx_q];

  // Counters idle at zero outside RUN; a sample is only taken while the run
  // continues, so the limit flags are evaluated on registered counts.
  assign cnt_clr = (state_q != RUN);
  assign cnt_en  = (state_q == RUN) && g_req && !run_hit && !smp_out;

  eq_run_counter #(
    .RUN_LEN    (RUN_LEN),
    .MAX_SAMPLES(MAX_SAMPLES)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .a      (g_a),
    .b      (g_b),
    .run_hit(run_hit),
    .smp_out(smp_out)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hit_d     = 1'b0;
    aborted_d = 1'b0;
    done_ch_d = done_ch_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = RUN;
          gidx_d  = pick_idx;
          grant_d = N_CH'(1) << pick_idx;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (!g_req || run_hit || smp_out) begin
          state_d   = REPORT;
          grant_d   = '0;
          done_d    = 1'b1;
          done_ch_d = gidx_q;
          ptr_d     = gidx_q;
          aborted_d = !g_req;
          hit_d     = g_req && run_hit;
        end
      end
      REPORT: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= CH_W'(N_CH - 1);
      gidx_q    <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      aborted_q <= 1'b0;
      done_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hit_q     <= hit_d;
      aborted_q <= aborted_d;
      done_ch_q <= done_ch_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hit     = hit_q;
  assign bus.aborted = aborted_q;
  assign bus.done_ch = done_ch_q;

endmodule

// File: tb/tb_eq_run_arbiter.sv
// Bench for eq_run_arbiter: two instances (MAX_SAMPLES 16 and 4) see the same
// stimulus and are compared every cycle against a transaction-style model.
module tb_eq_run_arbiter;
  import eq_run_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eq_run_arbiter_if #(.N_CH(N)) bus0 ();
  eq_run_arbiter_if #(.N_CH(N)) bus1 ();

  eq_run_arbiter #(.N_CH(N), .RUN_LEN(4), .MAX_SAMPLES(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  eq_run_arbiter #(.N_CH(N), .RUN_LEN(4), .MAX_SAMPLES(4)) dut_short (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: which channel is being served, the match history of its accepted
  // samples, and the output values expected after the next clock edge.
  typedef struct {
    int          serving;   // -1 when none
    bit          reporting;
    int          ptr;
    logic [63:0] hist;      // bit 0 = most recent accepted sample matched
    int          n;         // accepted samples
    logic [3:0]  grant;
    bit          busy;
    bit          done;
    bit          hit;
    bit          aborted;
    int          done_ch;
  } mdl_t;

  mdl_t m[2];
  int   run_len[2] = '{4, 4};
  int   max_smp[2] = '{16, 4};

  function automatic int trailing_run(input logic [63:0] h, input int n);
    int c = 0;
    while (c < n && h[c[5:0]]) c++;
    return c;
  endfunction

  task automatic mdl_reset(input int k);
    m[k].serving   = -1;
    m[k].reporting = 1'b0;
    m[k].ptr       = N - 1;
    m[k].hist      = '0;
    m[k].n         = 0;
    m[k].grant     = '0;
    m[k].busy      = 1'b0;
    m[k].done      = 1'b0;
    m[k].hit       = 1'b0;
    m[k].aborted   = 1'b0;
    m[k].done_ch   = 0;
  endtask

  task automatic mdl_finish(input int k, input bit h, input bit ab);
    m[k].done_ch   = m[k].serving;
    m[k].ptr       = m[k].serving;
    m[k].serving   = -1;
    m[k].reporting = 1'b1;
    m[k].grant     = '0;
    m[k].busy      = 1'b1;
    m[k].done      = 1'b1;
    m[k].hit       = h;
    m[k].aborted   = ab;
  endtask

  task automatic mdl_step(input int k, input logic [3:0] r, input logic [3:0] a,
                          input logic [3:0] b);
    m[k].done    = 1'b0;
    m[k].hit     = 1'b0;
    m[k].aborted = 1'b0;
    if (m[k].reporting) begin
      m[k].reporting = 1'b0;
      m[k].busy      = 1'b0;
    end else if (m[k].serving >= 0) begin
      int g = m[k].serving;
      if (!r[g]) mdl_finish(k, 1'b0, 1'b1);
      else if (trailing_run(m[k].hist, m[k].n) >= run_len[k]) mdl_finish(k, 1'b1, 1'b0);
      else if (m[k].n >= max_smp[k]) mdl_finish(k, 1'b0, 1'b0);
      else begin
        m[k].hist = {m[k].hist[62:0], a[g] == b[g]};
        m[k].n++;
      end
    end else if (r != 4'b0) begin
      bit found = 1'b0;
      for (int i = 1; i <= N; i++) begin
        int c = (m[k].ptr + i) % N;
        if (!found && r[c]) begin
          found        = 1'b1;
          m[k].serving = c;
          m[k].hist    = '0;
          m[k].n       = 0;
          m[k].grant   = 4'(1 << c);
          m[k].busy    = 1'b1;
        end
      end
    end
  endtask

  task automatic cmp(input int k, input logic [3:0] gr, input logic bs, input logic dn,
                     input logic ht, input logic ab, input logic [1:0] dc);
    check($sformatf("u%0d grant", k), 32'(gr), 32'(m[k].grant));
    check($sformatf("u%0d busy", k), 32'(bs), 32'(m[k].busy));
    check($sformatf("u%0d done", k), 32'(dn), 32'(m[k].done));
    check($sformatf("u%0d hit", k), 32'(ht), 32'(m[k].hit));
    check($sformatf("u%0d aborted", k), 32'(ab), 32'(m[k].aborted));
    check($sformatf("u%0d done_ch", k), 32'(dc), 32'(m[k].done_ch));
  endtask

  task automatic cmp_both();
    cmp(0, bus0.grant, bus0.busy, bus0.done, bus0.hit, bus0.aborted, bus0.done_ch);
    cmp(1, bus1.grant, bus1.busy, bus1.done, bus1.hit, bus1.aborted, bus1.done_ch);
  endtask

  // One clock: check what the last edge produced, then apply the next inputs.
  task automatic cycle(input bit rv, input logic [3:0] r, input logic [3:0] a,
                       input logic [3:0] b);
    @(negedge clk);
    cmp_both();
    rst      = rv;
    bus0.req = r;
    bus0.a   = a;
    bus0.b   = b;
    bus1.req = r;
    bus1.a   = a;
    bus1.b   = b;
    for (int k = 0; k < 2; k++) begin
      if (rv) mdl_reset(k);
      else mdl_step(k, r, a, b);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) cycle(1'b0, 4'b0000, 4'b0000, 4'b0000);
  endtask

  initial begin
    logic [3:0] av;
    logic [3:0] mm;
    logic [3:0] r;
    bus0.req = '0; bus0.a = '0; bus0.b = '0;
    bus1.req = '0; bus1.a = '0; bus1.b = '0;
    mdl_reset(0);
    mdl_reset(1);

    // Reset state
    repeat (3) cycle(1'b1, 4'b0000, 4'b0000, 4'b0000);
    idle(2);

    // Single requester, every sample matches
    repeat (8) begin
      av = 4'($urandom);
      cycle(1'b0, 4'b0001, av, av);
    end
    idle(3);

    // Mismatch on every third sample: never a run of 4
    for (int i = 0; i < 24; i++) begin
      av = 4'($urandom);
      cycle(1'b0, 4'b0010, av, av ^ ((i % 3 == 2) ? 4'b0010 : 4'b0000));
    end
    idle(3);

    // All channels requesting, all matching: round-robin rotation
    repeat (30) begin
      av = 4'($urandom);
      cycle(1'b0, 4'b1111, av, av);
    end
    idle(3);

    // Granted request dropped mid-run
    cycle(1'b0, 4'b0100, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0100, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000, 4'b0000);
    idle(3);

    // Asynchronous reset between clock edges while a channel is in RUN
    repeat (3) cycle(1'b0, 4'b0010, 4'b0000, 4'b0000);
    @(negedge clk);
    cmp_both();
    #2 rst = 1'b1;
    #1;
    check("async grant u0", 32'(bus0.grant), 32'd0);
    check("async busy u0", 32'(bus0.busy), 32'd0);
    check("async done u0", 32'(bus0.done), 32'd0);
    check("async grant u1", 32'(bus1.grant), 32'd0);
    check("async busy u1", 32'(bus1.busy), 32'd0);
    mdl_reset(0);
    mdl_reset(1);
    cycle(1'b1, 4'b1111, 4'b0000, 4'b0000);
    repeat (8) cycle(1'b0, 4'b1111, 4'b0000, 4'b0000);
    idle(3);

    // Random traffic: slowly changing requests, mostly matching operands
    r = '0;
    repeat (1500) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
      av = 4'($urandom);
      mm = '0;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) mm[i] = 1'b1;
      cycle(1'b0, r, av, av ^ mm);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
